// File: rtl/min2_stream_acc.sv
// min2_stream_acc: streaming min / second-min / argmin accumulator.
// Accepts P magnitude lanes per beat, folds a row of up to DMAX entries
// into (min, min2, min_idx) and presents the result with a valid/ready
// handshake one cycle after the last beat of the row is accepted.
// Optional feature: define SIGN_PROD_EN to add per-lane sign inputs and a
// registered sign-product output (sgn) for the row.
module min2_stream_acc #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8,
  parameter int P      = 4,
  parameter int DMAX   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    deg,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W*P-1:0] in_data,
`ifdef SIGN_PROD_EN
  input  logic [P-1:0]        in_sign,
  output logic                sgn,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   min,
  output logic [DATA_W-1:0]   min2,
  output logic [IDX_W-1:0]    min_idx
);

  // Wide enough to hold (beat_cnt + 1) * P without wrapping.
  localparam int POS_W = IDX_W + $clog2(P + 1) + 1;

  typedef enum logic {S_FIRST, S_ACC} state_t;

  state_t            state;
  logic [IDX_W-1:0]  beat_cnt;
  logic [IDX_W-1:0]  deff_q;
  logic [DATA_W-1:0] acc_min;
  logic [DATA_W-1:0] acc_min2;
  logic [IDX_W-1:0]  acc_idx;

  logic              accept;
  logic              last_beat;
  logic [IDX_W-1:0]  deff_new;
  logic [IDX_W-1:0]  deff_cur;
  logic [POS_W-1:0]  beat_base;
  logic [POS_W-1:0]  beat_end;
  logic [P-1:0]      lane_ok;

  logic [DATA_W-1:0] nx_min;
  logic [DATA_W-1:0] nx_min2;
  logic [IDX_W-1:0]  nx_idx;
  logic              have;
  logic [POS_W-1:0]  lane_pos;
  logic [DATA_W-1:0] lane_val;

`ifdef SIGN_PROD_EN
  logic acc_sgn;
  logic nx_sgn;
`endif

  // A new beat can enter whenever the output slot is empty or being drained.
  assign accept   = in_valid && in_ready;
  assign in_ready = !out_valid || out_ready;

  // Effective degree: live deg on the first beat, the latched value after.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path before any
    // conditional logic, otherwise synthesis infers a latch.
    deff_new = deg;
    if (deg == '0 || deg > IDX_W'(DMAX)) deff_new = IDX_W'(DMAX);
    deff_cur  = (state == S_FIRST) ? deff_new : deff_q;
    beat_base = POS_W'(beat_cnt) * POS_W'(P);
    beat_end  = (POS_W'(beat_cnt) + POS_W'(1)) * POS_W'(P);
    last_beat = (beat_end >= POS_W'(deff_cur));
  end

  // Fold the beat's in-range lanes, in position order, into the running
  // accumulator; a first beat starts from an empty accumulator.
  always_comb begin
    have     = (state == S_ACC);
    nx_min   = acc_min;
    nx_min2  = acc_min2;
    nx_idx   = acc_idx;
    lane_ok  = '0;
    lane_pos = '0;
    lane_val = '0;
    for (int k = 0; k < P; k++) begin
      lane_pos   = beat_base + POS_W'(k);
      lane_val   = in_data[DATA_W*k +: DATA_W];
      lane_ok[k] = (lane_pos < POS_W'(deff_cur));
      if (lane_ok[k]) begin
        if (!have) begin
          nx_min  = lane_val;
          nx_min2 = '1;
          nx_idx  = IDX_W'(lane_pos);
          have    = 1'b1;
        end else if (lane_val < nx_min) begin
          // Strict compare: an equal value keeps the earlier position as
          // min and lands in min2 through the branch below.
          nx_min2 = nx_min;
          nx_min  = lane_val;
          nx_idx  = IDX_W'(lane_pos);
        end else if (lane_val < nx_min2) begin
          nx_min2 = lane_val;
        end
      end
    end
  end

`ifdef SIGN_PROD_EN
  // Running XOR of the signs of in-range lanes.
  always_comb begin
    nx_sgn = (state == S_ACC) ? acc_sgn : 1'b0;
    for (int k = 0; k < P; k++) begin
      if (lane_ok[k]) nx_sgn = nx_sgn ^ in_sign[k];
    end
  end
`endif

  // Row FSM, accumulator and registered result with output handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_FIRST;
      beat_cnt  <= '0;
      deff_q    <= '0;
      acc_min   <= '0;
      acc_min2  <= '0;
      acc_idx   <= '0;
      out_valid <= 1'b0;
      min       <= '0;
      min2      <= '0;
      min_idx   <= '0;
`ifdef SIGN_PROD_EN
      acc_sgn   <= 1'b0;
      sgn       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        acc_min  <= nx_min;
        acc_min2 <= nx_min2;
        acc_idx  <= nx_idx;
`ifdef SIGN_PROD_EN
        acc_sgn  <= nx_sgn;
`endif
        if (state == S_FIRST) deff_q <= deff_new;
        if (last_beat) begin
          state    <= S_FIRST;
          beat_cnt <= '0;
        end else begin
          state    <= S_ACC;
          beat_cnt <= beat_cnt + IDX_W'(1);
        end
      end

      if (accept && last_beat) begin
        out_valid <= 1'b1;
        min       <= nx_min;
        min2      <= nx_min2;
        min_idx   <= nx_idx;
`ifdef SIGN_PROD_EN
        sgn       <= nx_sgn;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_min2_stream_acc.sv
// Directed, table-driven bench for min2_stream_acc (P=4, DATA_W=8,
// IDX_W=8, DMAX=32). Inputs change on the falling edge; outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_min2_stream_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  deg;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  min;
  logic [7:0]  min2;
  logic [7:0]  min_idx;
`ifdef SIGN_PROD_EN
  logic [3:0]  in_sign;
  logic        sgn;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  min2_stream_acc #(.DATA_W(8), .IDX_W(8), .P(4), .DMAX(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .deg       (deg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SIGN_PROD_EN
    .in_sign   (in_sign),
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .min       (min),
    .min2      (min2),
    .min_idx   (min_idx)
  );

  typedef struct packed {
    logic [7:0]       deg;
    logic [3:0]       nbeats;
    logic [7:0][31:0] beats;
    logic [7:0]       emin;
    logic [7:0]       emin2;
    logic [7:0]       eidx;
  } vec_t;

  localparam int NV = 9;
  vec_t tv [NV];

  function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stream one row with out_ready high; deg is driven only meaningfully on
  // the first beat (later beats carry 0 to prove it is latched).
  task automatic run_row(input vec_t v, input string tag);
    for (int b = 0; b < int'(v.nbeats); b++) begin
      @(negedge clk);
      if (b == 0) check({tag, " in_ready"}, in_ready, 1);
      if (b == int'(v.nbeats) - 1) check({tag, " early out_valid"}, out_valid, 0);
      in_valid = 1'b1;
      in_data  = v.beats[b];
      deg      = (b == 0) ? v.deg : 8'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " min"},       min,       v.emin);
    check({tag, " min2"},      min2,      v.emin2);
    check({tag, " min_idx"},   min_idx,   v.eidx);
    @(negedge clk);
    check({tag, " out_valid clear"}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;

    // deg=8 two beats
    tv[0] = '0; tv[0].deg = 8; tv[0].nbeats = 2;
    tv[0].beats[0] = pack4(9, 3, 7, 5); tv[0].beats[1] = pack4(6, 2, 8, 4);
    tv[0].emin = 2; tv[0].emin2 = 3; tv[0].eidx = 5;
    // deg=5: lanes 1-3 of beat 2 hold 0 and must be ignored
    tv[1] = '0; tv[1].deg = 5; tv[1].nbeats = 2;
    tv[1].beats[0] = pack4(4, 4, 9, 9); tv[1].beats[1] = pack4(1, 0, 0, 0);
    tv[1].emin = 1; tv[1].emin2 = 4; tv[1].eidx = 4;
    // deg=3 single beat, tie at 7
    tv[2] = '0; tv[2].deg = 3; tv[2].nbeats = 1;
    tv[2].beats[0] = pack4(7, 7, 7, 0);
    tv[2].emin = 7; tv[2].emin2 = 7; tv[2].eidx = 0;
    // deg=1: min2 all ones
    tv[3] = '0; tv[3].deg = 1; tv[3].nbeats = 1;
    tv[3].beats[0] = pack4(200, 0, 0, 0);
    tv[3].emin = 200; tv[3].emin2 = 255; tv[3].eidx = 0;
    // deg=0 -> 32 entries, 8 beats
    tv[4] = '0; tv[4].deg = 0; tv[4].nbeats = 8;
    for (int b = 0; b < 8; b++) tv[4].beats[b] = pack4(50, 50, 50, 50);
    tv[4].beats[4][15:8]  = 8'd10;   // position 17
    tv[4].beats[7][23:16] = 8'd12;   // position 30
    tv[4].emin = 10; tv[4].emin2 = 12; tv[4].eidx = 17;
    // deg=40 > DMAX -> 32 entries, tie between first and last position
    tv[5] = '0; tv[5].deg = 40; tv[5].nbeats = 8;
    for (int b = 0; b < 8; b++) tv[5].beats[b] = pack4(50, 50, 50, 50);
    tv[5].beats[0][7:0]   = 8'd1;    // position 0
    tv[5].beats[7][31:24] = 8'd1;    // position 31
    tv[5].emin = 1; tv[5].emin2 = 1; tv[5].eidx = 0;
    // deg=6, all-ones values; out-of-range lanes carry 0
    tv[6] = '0; tv[6].deg = 6; tv[6].nbeats = 2;
    tv[6].beats[0] = pack4(255, 255, 255, 255); tv[6].beats[1] = pack4(255, 255, 0, 0);
    tv[6].emin = 255; tv[6].emin2 = 255; tv[6].eidx = 0;
    // deg=4 single beat, tie at 6
    tv[7] = '0; tv[7].deg = 4; tv[7].nbeats = 1;
    tv[7].beats[0] = pack4(8, 6, 6, 9);
    tv[7].emin = 6; tv[7].emin2 = 6; tv[7].eidx = 1;
    // deg=2 single beat
    tv[8] = '0; tv[8].deg = 2; tv[8].nbeats = 1;
    tv[8].beats[0] = pack4(3, 1, 0, 0);
    tv[8].emin = 1; tv[8].emin2 = 3; tv[8].eidx = 1;

    rst = 1'b1; deg = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef SIGN_PROD_EN
    in_sign = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", out_valid, 0);
    check("reset min",       min,       0);
    check("reset min2",      min2,      0);
    check("reset min_idx",   min_idx,   0);
    @(negedge clk);
    check("reset in_ready",  in_ready,  1);

    for (int i = 0; i < NV; i++) run_row(tv[i], $sformatf("row%0d", i));

    // Back-to-back single-beat rows at full throughput.
    @(negedge clk);
    in_valid = 1'b1; deg = 2; in_data = pack4(10, 20, 0, 0);
    @(negedge clk);
    check("b2b in_ready", in_ready, 1);
    in_data = pack4(30, 15, 0, 0);
    check("b2b A out_valid", out_valid, 1);
    check("b2b A min",       min,       10);
    check("b2b A min2",      min2,      20);
    check("b2b A min_idx",   min_idx,   0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b B out_valid", out_valid, 1);
    check("b2b B min",       min,       15);
    check("b2b B min2",      min2,      30);
    check("b2b B min_idx",   min_idx,   1);
    @(negedge clk);
    check("b2b clear", out_valid, 0);

    // Backpressure: result held for 3 cycles while a second row waits.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; deg = 4; in_data = pack4(5, 6, 7, 8);
    @(negedge clk);
    in_data = pack4(9, 3, 4, 4);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      check("bp in_ready low", in_ready,  0);
      check("bp out_valid",    out_valid, 1);
      check("bp min",          min,       5);
      check("bp min2",         min2,      6);
      check("bp min_idx",      min_idx,   0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp row2 out_valid", out_valid, 1);
    check("bp row2 min",       min,       3);
    check("bp row2 min2",      min2,      4);
    check("bp row2 min_idx",   min_idx,   1);
    @(negedge clk);
    check("bp row2 clear", out_valid, 0);

    // Reset in the middle of a row: the partial row must vanish.
    @(negedge clk);
    in_valid = 1'b1; deg = 8; in_data = pack4(0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst min",       min,       0);
    check("midrst in_ready",  in_ready,  1);
    @(negedge clk);
    check("midrst no output", out_valid, 0);
    rv = '0; rv.deg = 8; rv.nbeats = 2;
    rv.beats[0] = pack4(1, 2, 3, 4); rv.beats[1] = pack4(5, 6, 7, 8);
    rv.emin = 1; rv.emin2 = 2; rv.eidx = 0;
    run_row(rv, "post-reset row");

`ifdef SIGN_PROD_EN
    // Sign product: 1011 ^ 0001 over 8 lanes -> even count -> 0.
    @(negedge clk);
    in_valid = 1'b1; deg = 8; in_data = pack4(1, 2, 3, 4); in_sign = 4'b1011;
    @(negedge clk);
    deg = 0; in_data = pack4(5, 6, 7, 8); in_sign = 4'b0001;
    @(negedge clk);
    in_valid = 1'b0; in_sign = '0;
    check("sgn deg8", sgn, 0);
    // deg=5: 0001 then 1110 with only lane 0 in range -> 1.
    @(negedge clk);
    in_valid = 1'b1; deg = 5; in_data = pack4(1, 2, 3, 4); in_sign = 4'b0001;
    @(negedge clk);
    deg = 0; in_data = pack4(5, 6, 7, 8); in_sign = 4'b1110;
    @(negedge clk);
    in_valid = 1'b0; in_sign = '0;
    check("sgn deg5", sgn, 1);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/min2_stream_acc.md
MIN2_STREAM_ACC -- requirements
Module: min2_stream_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8: magnitude width in bits.
REQ-002 SHALL have parameter IDX_W, default 8: index width in bits; 2^IDX_W > DMAX.
REQ-003 SHALL have parameter P, default 4: lanes per input beat, P >= 1.
REQ-004 SHALL have parameter DMAX, default 32: maximum row degree.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-007 SHALL have port deg, input, IDX_W bits: row degree, sampled on the first beat of a row.
REQ-008 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port in_data, input, DATA_W*P bits: lane k holds bits [DATA_W*k +: DATA_W].
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have ports min, min2, output, DATA_W bits each: smallest and second-smallest magnitudes of the row.
REQ-014 SHALL have port min_idx, output, IDX_W bits: row position of min.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-016 SHALL assign row position b*P+k to lane k of accepted beat b (b counts from 0 within the row).
REQ-017 SHALL use effective degree Deff = DMAX when deg==0 or deg>DMAX, else deg; a row spans ceil(Deff/P) beats.
REQ-018 SHALL ignore lanes with position >= Deff in the final beat.
REQ-019 SHALL run a two-state FSM. FIRST: no row open. ACC: row open. FIRST->ACC when the accepted beat is not the last of the row. ACC->FIRST when the last beat is accepted. A single-beat row stays in FIRST.
REQ-020 SHALL merge each accepted beat combinationally into the min/min2/idx accumulator; a first beat replaces the accumulator contents.
REQ-021 SHALL resolve ties by lower position: equal values give min the lower position, and min2 equals that same value.
REQ-022 SHALL load min, min2 and min_idx and assert out_valid on the clock edge that accepts the last beat, giving 1-cycle latency.
REQ-023 SHALL hold the outputs stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on out_ready unless a last beat is accepted in the same cycle, in which case the new result loads, allowing back-to-back rows at full throughput.
REQ-025 SHALL output min2 = all ones when Deff==1.

Reset
REQ-026 SHALL, with rst high at a clock edge, set the FSM to FIRST, clear the beat counter and accumulator, set out_valid=0, min=0, min2=0 and min_idx=0.
REQ-027 SHALL discard any partially accumulated row on reset, with no output produced for it.
REQ-028 SHALL drive in_ready=1 in the cycle after reset.

Configuration
REQ-029 SHALL, when SIGN_PROD_EN is defined, add input in_sign [P-1:0] and output sgn (1 bit); sgn is the XOR of the valid-lane signs of the row and is registered with min.
REQ-030 SHALL, when SIGN_PROD_EN is not defined, omit in_sign, sgn and the associated logic.

Verification
REQ-031 SHALL cover: P=4, deg=8, beats {9,3,7,5},{6,2,8,4} -> out_valid 1 cycle after beat 2; min=2, min2=3, min_idx=5.
REQ-032 SHALL cover: deg=5, beats {4,4,9,9},{1,X,X,X} -> min=1, min2=4, min_idx=4; lanes 1-3 of beat 2 ignored.
REQ-033 SHALL cover: deg=3, single beat {7,7,7,0} -> min=7, min2=7, min_idx=0; lane 3 ignored.
REQ-034 SHALL cover: out_ready held low for 3 cycles with a second row pending -> in_ready=0; outputs stable; second row result follows with no loss.
REQ-035 SHALL cover: rst pulsed after beat 1 of an 8-degree row, then a fresh row {1,2,3,4},{5,6,7,8} -> min=1, min2=2, min_idx=0.
REQ-036 SHALL cover, with SIGN_PROD_EN defined: signs 1011 and 0001, deg=8 -> sgn=0.
